// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, drives the synchronous instruction
// memory, pairs each returned instruction with its PC and presents a registered,
// valid-qualified pair to IF/ID. A one-entry skid buffer catches the response
// that lands on the first stall cycle. A redirect flushes all fetch state and
// opens a fixed-length squash window.
module fetch_unit #(
  parameter logic [31:0] RESET_PC      = 32'd0,
  parameter int unsigned IMEM_AW       = 8,
  parameter logic [31:0] NOP_INSTR     = 32'h0000_0000,
  parameter int unsigned SQUASH_CYCLES = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        if_instr,
  output logic [31:0]        if_pc,
  output logic               if_valid,
  output logic               squash_active
);

  localparam int unsigned SqW = (SQUASH_CYCLES > 0) ? $clog2(SQUASH_CYCLES + 1) : 1;
  localparam logic [SqW-1:0] SqLoad = SqW'(SQUASH_CYCLES);

  logic [31:0]    fetch_pc_q;
  logic           rsp_valid_q;
  logic [31:0]    rsp_pc_q;
  logic           skid_valid_q;
  logic [31:0]    skid_instr_q;
  logic [31:0]    skid_pc_q;
  logic [SqW-1:0] sq_cnt_q;
  logic [SqW-1:0] sq_cnt_d;

  assign imem_addr = fetch_pc_q[IMEM_AW-1:0];

  // PC, response tracking, skid buffer and IF/ID output registers.
  // Priority: redirect > stall > normal flow.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q   <= RESET_PC;
      rsp_valid_q  <= 1'b0;
      rsp_pc_q     <= 32'd0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= 32'd0;
      if_valid     <= 1'b0;
      if_instr     <= NOP_INSTR;
      if_pc        <= 32'd0;
    end else if (redirect_valid) begin
      // Kill the in-flight fetch and any skid entry; if_pc keeps its last value.
      fetch_pc_q   <= redirect_pc;
      rsp_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      if_valid     <= 1'b0;
      if_instr     <= NOP_INSTR;
    end else if (stall) begin
      // The address re-presented during a stall is not counted as issued, so
      // only the response arriving on the first stall cycle needs parking.
      rsp_valid_q <= 1'b0;
      if (rsp_valid_q) begin
        skid_valid_q <= 1'b1;
        skid_instr_q <= imem_rdata;
        skid_pc_q    <= rsp_pc_q;
      end
    end else begin
      fetch_pc_q  <= fetch_pc_q + 32'd1;
      rsp_valid_q <= 1'b1;
      rsp_pc_q    <= fetch_pc_q;
      if (skid_valid_q) begin
        skid_valid_q <= 1'b0;
        if_valid     <= 1'b1;
        if_instr     <= skid_instr_q;
        if_pc        <= skid_pc_q;
      end else if (rsp_valid_q) begin
        if_valid <= 1'b1;
        if_instr <= imem_rdata;
        if_pc    <= rsp_pc_q;
      end else begin
        if_valid <= 1'b0;
        if_instr <= NOP_INSTR;
      end
    end
  end

  // Squash counter next state: reload on redirect, otherwise count down to zero.
  always_comb begin
    sq_cnt_d = sq_cnt_q;
    if (redirect_valid) begin
      sq_cnt_d = SqLoad;
    end else if (sq_cnt_q != '0) begin
      sq_cnt_d = sq_cnt_q - SqW'(1);
    end
  end

  // Squash counter and its registered flag; counts down through stalls too.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sq_cnt_q      <= '0;
      squash_active <= 1'b0;
    end else begin
      sq_cnt_q      <= sq_cnt_d;
      squash_active <= (sq_cnt_d != '0);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: randomized and directed stall/redirect
// stimulus, a queue of expected in-order PCs, and a negedge monitor.
module tb_fetch_unit;

  localparam int unsigned AW = 8;
  localparam int unsigned SQ = 2;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          stall = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [31:0]   redirect_pc = 32'd0;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata = 32'd0;
  logic [31:0]   if_instr;
  logic [31:0]   if_pc;
  logic          if_valid;
  logic          squash_active;

  fetch_unit #(
    .RESET_PC     (32'd0),
    .IMEM_AW      (AW),
    .NOP_INSTR    (NOP),
    .SQUASH_CYCLES(SQ)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .if_valid      (if_valid),
    .squash_active (squash_active)
  );

  always #5 clock = ~clock;

  // Synchronous instruction memory, one-cycle read latency.
  logic [31:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i);
  always @(posedge clock) imem_rdata <= mem[imem_addr];

  // Reference model: the program-order PC stream the pipeline must consume,
  // the number of unstalled cycles since the last restart, and squash cycles left.
  logic [31:0] exp_q [$];
  int          ok_cnt = 0;
  int          sq_left = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic        snap_valid;
  logic [31:0] snap_pc;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail_timeout(input string name, input int bound);
    n_checks++;
    $display("FAIL %s: condition not reached within %0d cycles, got if_pc=%0h, expected a match",
             name, bound, if_pc);
  endtask

  function automatic void restart(input logic [31:0] pc);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(pc + 32'(i));
  endfunction

  // End-of-cycle model update, called after the monitor has sampled this cycle.
  function automatic void update_model();
    if (!reset_n) begin
      restart(32'd0);
      ok_cnt  = 0;
      sq_left = 0;
    end else if (redirect_valid) begin
      restart(redirect_pc);
      ok_cnt  = 0;
      sq_left = SQ;
    end else begin
      if (!stall && ok_cnt < 2) ok_cnt++;
      if (sq_left > 0) sq_left--;
    end
    while (exp_q.size() < 8) exp_q.push_back(exp_q[$] + 32'd1);
  endfunction

  // Monitor: output consumed by IF/ID whenever valid and not stalled.
  logic        prev_stall = 1'b0;
  logic        prev_redir = 1'b0;
  logic        prev_rst = 1'b0;
  logic [95:0] prev_out = '0;
  logic [31:0] last_pc = 32'd0;

  always @(negedge clock) begin
    if (!reset_n) begin
      check("reset_state", {squash_active, if_valid, if_instr, if_pc},
            {1'b0, 1'b0, NOP, 32'd0});
      last_pc = 32'd0;
    end else begin
      check("valid_timing", 96'(if_valid), 96'(ok_cnt >= 2));
      check("squash_active", 96'(squash_active), 96'(sq_left != 0));
      if (!if_valid) begin
        check("bubble_instr", 96'(if_instr), 96'(NOP));
        check("bubble_pc_hold", 96'(if_pc), 96'(last_pc));
      end else if (!stall) begin
        if (exp_q.size() == 0) begin
          fail_timeout("scoreboard_empty", 0);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          check("if_pc", 96'(if_pc), 96'(e));
          check("if_instr", 96'(if_instr), 96'(mem[e[7:0]]));
        end
      end
      if (prev_stall && !prev_redir && prev_rst)
        check("stall_hold", 96'({if_valid, if_instr, if_pc}), prev_out);
      last_pc = if_pc;
    end
    prev_stall = stall;
    prev_redir = redirect_valid;
    prev_rst   = reset_n;
    prev_out   = 96'({if_valid, if_instr, if_pc});
  end

  // One cycle of stimulus; entered and left at a rising edge.
  task automatic step(input logic s, input logic r, input logic [31:0] pc);
    #1;
    stall          = s;
    redirect_valid = r;
    redirect_pc    = pc;
    @(negedge clock);
    #1;
    snap_valid = if_valid;
    snap_pc    = if_pc;
    update_model();
    @(posedge clock);
  endtask

  // Asynchronous reset mid-cycle for n cycles; optionally check outputs clear before the next edge.
  task automatic do_reset(input int n, input bit chk);
    #3 reset_n = 1'b0;
    if (chk) begin
      #1;
      check("async_reset", {squash_active, if_valid, if_instr, if_pc}, {1'b0, 1'b0, NOP, 32'd0});
    end
    @(negedge clock);
    #1 update_model();
    for (int i = 1; i < n; i++) begin
      @(posedge clock);
      @(negedge clock);
      #1 update_model();
    end
    @(posedge clock);
    #1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    #2 reset_n = 1'b1;
    @(negedge clock);
    #1 update_model();
    @(posedge clock);
  endtask

  task automatic wait_pc(input logic [31:0] pc);
    bit found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      step(1'b0, 1'b0, 32'd0);
      if (snap_valid && snap_pc == pc) found = 1'b1;
    end
    if (!found) fail_timeout("wait_pc", 60);
  endtask

  initial begin
    restart(32'd0);
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    @(posedge clock);
    do_reset(3, 1'b0);

    // Stall for three cycles while if_pc=5.
    wait_pc(32'd4);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'd0);

    // Redirect to 0x40 while if_pc=10.
    wait_pc(32'd9);
    step(1'b0, 1'b1, 32'h40);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'd0);

    // Redirect together with stall while the skid holds an entry.
    step(1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b1, 32'h20);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'd0);

    // Back-to-back redirects.
    step(1'b0, 1'b1, 32'h40);
    step(1'b0, 1'b1, 32'h80);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'd0);

    // PC wrap through 32'hFFFF_FFFF.
    step(1'b0, 1'b1, 32'hFFFF_FFFD);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'd0);

    // Randomized stalls and redirects.
    for (int i = 0; i < 600; i++) begin
      logic        s;
      logic        r;
      logic [31:0] pc;
      s  = ($urandom_range(0, 9) < 3);
      r  = ($urandom_range(0, 19) == 0);
      pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
      step(s, r, pc);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'd0);

    // Reset dropped mid-stall with the skid occupied, after a redirect so squash is live.
    step(1'b0, 1'b1, 32'h30);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0);
    do_reset(2, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end of the pipeline; sits directly upstream of the IF/ID buffer.
- Owns the PC and drives the synchronous instruction memory address.
- Aligns returned instructions with their PC and presents a registered, valid-qualified instruction/PC pair to IF/ID.
- Handles downstream stalls without losing the in-flight fetch, and handles WB-stage redirects (branch/jump) by flushing fetch state and signalling a squash window.

Parameters:
- RESET_PC, 32'd0, PC loaded on reset.
- IMEM_AW, 8, instruction memory address width; imem_addr = fetch_pc[IMEM_AW-1:0].
- NOP_INSTR, 32'h0000_0000, instruction driven on if_instr during bubbles (opcode 0000 = NOP).
- SQUASH_CYCLES, 2, number of cycles squash_active stays high after a redirect.

Ports:
- clock, input, 1, rising-edge clock.
- reset_n, input, 1, asynchronous active-low reset.
- stall, input, 1, downstream hold request; outputs must not change while high.
- redirect_valid, input, 1, taken branch/jump from WB (branchControl).
- redirect_pc, input, 32, target PC (jumpAddress).
- imem_addr, output, IMEM_AW, instruction memory read address; 1-cycle synchronous read.
- imem_rdata, input, 32, instruction for the address presented in the previous cycle.
- if_instr, output, 32, registered instruction to IF/ID.
- if_pc, output, 32, registered PC of if_instr.
- if_valid, output, 1, if_instr/if_pc hold a real instruction.
- squash_active, output, 1, high while ID/EX/WB stages must discard wrong-path instructions.

Behaviour:
- Internal state:
  - fetch_pc: address being issued.
  - rsp_valid and rsp_pc: track the fetch returning this cycle.
  - skid_valid, skid_instr, skid_pc: 1-entry skid buffer.
  - sq_cnt: squash counter, width clog2(SQUASH_CYCLES+1).
- Reset (async, reset_n=0):
  - fetch_pc=RESET_PC; rsp_valid=0; skid_valid=0; sq_cnt=0.
  - if_valid=0, if_instr=NOP_INSTR, if_pc=0, squash_active=0.
- imem_addr is combinational from fetch_pc.
- Latency: address issued in cycle N → imem_rdata in N+1 → if_* registered at the end of N+1, visible in N+2.
- Priority per clock edge: reset > redirect_valid > stall > normal.
- Normal (stall=0, no redirect):
  - fetch_pc <= fetch_pc+1, wrapping mod 2^32.
  - rsp_valid <= 1; rsp_pc <= fetch_pc.
  - If skid_valid: if_* <= skid, skid_valid <= 0.
  - Else if rsp_valid: if_* <= {imem_rdata, rsp_pc, 1}.
  - Else: if_valid <= 0, if_instr <= NOP_INSTR.
- Stall (stall=1, no redirect):
  - if_* and fetch_pc hold; rsp_valid <= 0, so the re-presented address is not counted as issued.
  - If rsp_valid: skid <= {imem_rdata, rsp_pc}, skid_valid <= 1.
  - At most one response is in flight, so the skid never overflows.
  - Stall release emits the skid entry with no bubble and no duplicate.
- Redirect (redirect_valid=1, regardless of stall):
  - fetch_pc <= redirect_pc; rsp_valid <= 0; skid_valid <= 0.
  - if_valid <= 0, if_instr <= NOP_INSTR; sq_cnt <= SQUASH_CYCLES.
  - First target instruction appears on if_* two cycles after the redirect edge.
- Squash:
  - squash_active = (sq_cnt != 0), registered.
  - sq_cnt decrements by 1 per cycle, including during stall.
  - A redirect during an active squash reloads sq_cnt.
- Modes: RUN (sq_cnt=0, stall=0), HOLD (stall=1), SQUASH (sq_cnt!=0). Transitions follow the rules above.
- Bubbles: whenever if_valid=0, if_instr=NOP_INSTR and if_pc holds its last value.
- PC wrap: fetch_pc 32'hFFFF_FFFF → 0; imem_addr wraps within IMEM_AW.
- Reset mid-stall or mid-squash: all state clears immediately; fetch restarts at RESET_PC.

Test Plan:
- Reset release, stall=0, imem[i]=32'h1000_0000+i: cycle 2 after release shows if_valid=1, if_pc=0, if_instr=32'h1000_0000; if_pc then increments by 1 each cycle.
- Stall high for 3 cycles starting while if_pc=5: if_pc stays 5 for the whole stall; the next three cycles give if_pc=6,7,8 with correct instructions, no gaps, no repeats.
- redirect_valid pulse, redirect_pc=32'h40, while if_pc=10:
  - Next two cycles: if_valid=0, if_instr=0.
  - squash_active high for exactly 2 cycles.
  - Third cycle: if_pc=32'h40, if_instr=imem[8'h40].
- redirect_valid and stall both high in the same cycle, with skid full: skid discarded, redirect taken, first output is if_pc=redirect_pc.
- Second redirect (to 32'h80) one cycle after a first (to 32'h40): squash_active stays high 2 more cycles; no 32'h40-path instruction ever has if_valid=1.
- reset_n dropped mid-stall with skid_valid=1: all outputs return to reset values asynchronously (before the next clock edge); after release, fetch resumes from if_pc=0.
